// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types for the CPU run controller: host command codes, FSM state encodings
// and the program-load length helper.
package cpu_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_RUN    = 3'd3,
        ST_STEP   = 3'd4,
        ST_HALTED = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CMD_NOP    = 3'd0,
        CMD_LOAD   = 3'd1,
        CMD_RUN    = 3'd2,
        CMD_STEP   = 3'd3,
        CMD_HALT   = 3'd4,
        CMD_SETBRK = 3'd5
    } cmd_t;

    localparam int LOAD_CNT_W = 9;

    // A length byte of zero requests a full 256-word image.
    function automatic logic [LOAD_CNT_W-1:0] load_count(input logic [7:0] n);
        return (n == 8'd0) ? 9'd256 : {1'b0, n};
    endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             INC,
    output logic [CNT_W-1:0] Q
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (CLR) begin
            cnt_d = '0;
        end else if (INC && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        cnt_q <= cnt_d;
    end

    assign Q = cnt_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Host-side run controller: loads instruction memory, then sequences CPU execution
// (run, halt, single-step and a PC breakpoint) by gating CPU_EN.
module cpu_run_ctrl
    import cpu_run_ctrl_pkg::*;
#(
    parameter int WIDTH  = 13,
    parameter int IWIDTH = 5,
    parameter int CNT_W  = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [2:0]              HOST_CMD,
    input  logic                    HOST_CMD_VALID,
    output logic                    HOST_CMD_READY,
    input  logic [WIDTH-1:0]        HOST_DATA,
    input  logic                    HOST_DATA_VALID,
    output logic                    HOST_DATA_READY,
    output logic                    IMEM_WE,
    output logic [WIDTH-IWIDTH-1:0] IMEM_ADDR,
    output logic [WIDTH-1:0]        IMEM_WDATA,
    input  logic [WIDTH-IWIDTH-1:0] PC,
    output logic                    CPU_RST,
    output logic                    CPU_EN,
    output logic [2:0]              STATE,
    output logic                    BRK_HIT,
    output logic [CNT_W-1:0]        INSTR_CNT
);

    localparam int AW = WIDTH - IWIDTH;

    state_t                state_q, state_d;
    logic [AW-1:0]         ptr_q, ptr_d;
    logic [LOAD_CNT_W-1:0] remain_q, remain_d;
    logic [AW-1:0]         brk_addr_q, brk_addr_d;
    logic                  brk_en_q, brk_en_d;
    logic                  brk_hit_q, brk_hit_d;
    logic                  skip_q, skip_d;
    logic                  imem_we_q, imem_we_d;
    logic [AW-1:0]         imem_addr_q, imem_addr_d;
    logic [WIDTH-1:0]      imem_wdata_q, imem_wdata_d;

    logic cmd_ready, data_ready, cmd_fire, data_fire, brk_match, cpu_en;

    assign cmd_ready  = !RST && ((state_q == ST_IDLE) || (state_q == ST_HALTED) || (state_q == ST_RUN));
    assign data_ready = !RST && (state_q == ST_LOAD);
    assign cmd_fire   = HOST_CMD_VALID && cmd_ready;
    assign data_fire  = HOST_DATA_VALID && data_ready;

    // Skip lets the instruction sitting on the breakpoint execute once after (re)starting.
    assign brk_match = brk_en_q && (PC == brk_addr_q) && !skip_q;

    always_comb begin
        cpu_en = 1'b0;
        if (!RST) begin
            if (state_q == ST_RUN) begin
                cpu_en = !brk_match;
            end else if (state_q == ST_STEP) begin
                cpu_en = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        remain_d     = remain_q;
        brk_addr_d   = brk_addr_q;
        brk_en_d     = brk_en_q;
        brk_hit_d    = brk_hit_q;
        skip_d       = skip_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;

        if (cmd_fire && (HOST_CMD == CMD_SETBRK)) begin
            brk_addr_d = HOST_DATA[AW-1:0];
            brk_en_d   = HOST_DATA[AW];
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_fire && (HOST_CMD == CMD_LOAD)) begin
                    state_d  = ST_LOAD;
                    ptr_d    = '0;
                    remain_d = load_count(HOST_DATA[7:0]);
                end else if (cmd_fire && (HOST_CMD == CMD_RUN)) begin
                    state_d = ST_START;
                end
            end
            ST_LOAD: begin
                if (data_fire) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = ptr_q;
                    imem_wdata_d = HOST_DATA;
                    ptr_d        = ptr_q + 1'b1;
                    remain_d     = remain_q - 1'b1;
                    if (remain_q == 9'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_START: begin
                skip_d    = 1'b1;
                brk_hit_d = 1'b0;
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                skip_d = 1'b0;
                if (brk_match) begin
                    brk_hit_d = 1'b1;
                    state_d   = ST_HALTED;
                end else if (cmd_fire && (HOST_CMD == CMD_HALT)) begin
                    state_d = ST_HALTED;
                end
            end
            ST_STEP: begin
                state_d = ST_HALTED;
            end
            ST_HALTED: begin
                if (cmd_fire && (HOST_CMD == CMD_RUN)) begin
                    state_d   = ST_RUN;
                    skip_d    = 1'b1;
                    brk_hit_d = 1'b0;
                end else if (cmd_fire && (HOST_CMD == CMD_STEP)) begin
                    state_d   = ST_STEP;
                    brk_hit_d = 1'b0;
                end else if (cmd_fire && (HOST_CMD == CMD_LOAD)) begin
                    state_d  = ST_LOAD;
                    ptr_d    = '0;
                    remain_d = load_count(HOST_DATA[7:0]);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            remain_q     <= '0;
            brk_addr_q   <= '0;
            brk_en_q     <= 1'b0;
            brk_hit_q    <= 1'b0;
            skip_q       <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            remain_q     <= remain_d;
            brk_addr_q   <= brk_addr_d;
            brk_en_q     <= brk_en_d;
            brk_hit_q    <= brk_hit_d;
            skip_q       <= skip_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_instr_cnt (
        .CLK(CLK),
        .CLR(RST || (state_q == ST_START)),
        .INC(cpu_en),
        .Q  (INSTR_CNT)
    );

    assign HOST_CMD_READY  = cmd_ready;
    assign HOST_DATA_READY = data_ready;
    assign IMEM_WE         = imem_we_q;
    assign IMEM_ADDR       = imem_addr_q;
    assign IMEM_WDATA      = imem_wdata_q;
    assign CPU_RST         = !RST && (state_q == ST_START);
    assign CPU_EN          = cpu_en;
    assign STATE           = state_q;
    assign BRK_HIT         = brk_hit_q;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
- Host-side run controller for the one-cycle CPU.
- Loads program words into instruction memory over a valid/ready host interface.
- Issues the PC reset and sequences execution: run, halt, single-step and PC breakpoint.
- Sits between the host port and the CPU core. CPU_EN gates PC advance and every datapath write enable (EN_ACC, EN_REG_F, EN_D_MEM, PC_LD, BASE_REG_LD).

Parameters:
WIDTH, 13, instruction word width
IWIDTH, 5, opcode field width; address/PC width is WIDTH-IWIDTH (8)
CNT_W, 16, executed-instruction counter width

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  synchronous, active-high reset
HOST_CMD  in  3  command code
HOST_CMD_VALID  in  1  command valid
HOST_CMD_READY  out  1  command accepted when VALID&READY
HOST_DATA  in  WIDTH  command argument or program word
HOST_DATA_VALID  in  1  program word valid
HOST_DATA_READY  out  1  program word accepted when VALID&READY
IMEM_WE  out  1  instruction memory write strobe
IMEM_ADDR  out  WIDTH-IWIDTH  instruction memory write address
IMEM_WDATA  out  WIDTH  instruction memory write data
PC  in  WIDTH-IWIDTH  current CPU program counter
CPU_RST  out  1  PC reset pulse
CPU_EN  out  1  execute-enable for the current instruction
STATE  out  3  current FSM state
BRK_HIT  out  1  sticky breakpoint-halt flag
INSTR_CNT  out  CNT_W  executed-instruction count

Behaviour:
- Reset state and outputs:
  - RST takes priority over every other input.
  - State goes to IDLE. All registered outputs, the load pointer and the breakpoint register (address and enable) clear to 0.
  - While RST is high, READY outputs are forced to 0.
- Commands, taken on CMD_VALID&CMD_READY:
  - 0 NOP.
  - 1 LOAD: count N = HOST_DATA[7:0]; N=0 means 256.
  - 2 RUN.
  - 3 STEP.
  - 4 HALT.
  - 5 SETBRK: BRK_ADDR = HOST_DATA[7:0], BRK_EN = HOST_DATA[8].
  - Codes 6 and 7 are accepted with no effect. A command that is invalid in the current state is also accepted with no effect.
- HOST_CMD_READY is combinational: 1 in IDLE, HALTED and RUN; 0 in LOAD, START and STEP.
- States and transitions:
  - IDLE:
    - LOAD -> LOAD, with the load pointer cleared to 0.
    - RUN -> START.
    - STEP is ignored.
  - LOAD:
    - HOST_DATA_READY = 1.
    - Each data handshake registers IMEM_WE=1, IMEM_ADDR=pointer and IMEM_WDATA=HOST_DATA for exactly the next cycle, then increments the pointer (wraps modulo 256).
    - After the Nth word -> IDLE.
    - Commands are not accepted in this state.
  - START:
    - Lasts one cycle: CPU_RST=1, CPU_EN=0, INSTR_CNT cleared, BRK_HIT cleared, skip flag set. Then -> RUN.
  - RUN:
    - CPU_EN = !(BRK_EN && PC==BRK_ADDR && !skip). This output is combinational on PC so the breakpoint instruction is not executed.
    - On a breakpoint match -> HALTED and BRK_HIT=1.
    - Accepted HALT -> HALTED; CPU_EN is 0 from the next cycle.
    - HALT and breakpoint match in the same cycle -> HALTED with BRK_HIT=1.
    - Skip clears after the first RUN cycle.
  - HALTED:
    - RUN -> RUN, resuming without CPU_RST; sets skip and clears BRK_HIT.
    - STEP -> STEP; clears BRK_HIT.
    - LOAD -> LOAD.
    - SETBRK is allowed here.
  - STEP:
    - CPU_EN=1 for exactly one cycle, ignoring the breakpoint, then -> HALTED.
- SETBRK is accepted in IDLE, HALTED and RUN. It takes effect from the cycle after the handshake.
- INSTR_CNT increments on every cycle with CPU_EN=1 and saturates at 2^CNT_W-1.
- RST during LOAD aborts the load; words already written remain in memory.
- HOST_DATA_VALID outside LOAD is ignored (READY=0).
- STATE encoding: IDLE=0, LOAD=1, START=2, RUN=3, STEP=4, HALTED=5.

Decomposition:
- Shared include ctrl_cmd.v, next to instr_set.v, holds:
  - `define command codes (NOP, LOAD, RUN, STEP, HALT, SETBRK)
  - `define state encodings
- One sub-module, sat_counter (parameter CNT_W; ports CLK, CLR, INC, Q), implements INSTR_CNT.
- The breakpoint compare and FSM stay inline.

Test Plan:
- Load: RST, then LOAD N=3, then data {LDI,0x0F}, {ADDR,0x05}, {JMP,0x00} -> IMEM_WE pulses at addresses 0,1,2 with those words; state returns to IDLE (STATE=0); HOST_DATA_READY=0 afterwards.
- Run/halt: RUN from IDLE -> exactly one CPU_RST cycle with CPU_EN=0, then CPU_EN=1 continuously. HALT after 10 cycles -> CPU_EN=0 the next cycle, STATE=5, INSTR_CNT=10.
- Breakpoint: SETBRK 0x102 then RUN with PC stepping 0,1,2 -> CPU_EN=0 while PC=2, STATE=5, BRK_HIT=1, INSTR_CNT=2. A following RUN executes PC=2 (CPU_EN=1) without re-halting and clears BRK_HIT.
- Step: in HALTED issue STEP three times -> CPU_EN high for exactly one cycle per step; INSTR_CNT increases by 3; CMD_READY=0 only during the STEP cycle.
- Edge cases:
  - LOAD N=0 -> 256 words accepted; pointer wraps to 0.
  - HALT coinciding with a breakpoint match -> HALTED with BRK_HIT=1.
  - RST asserted mid-LOAD after 2 of 5 words -> STATE=0, all outputs 0, no further IMEM_WE.
